multicycle_ctrl_fsm: RTL and testbench

//  Multicycle RV32I control sequencer: one shared ALU/memory datapath, steps each instruction through

---
 rtl/riscv_ctrl_pkg.sv | 76 +++++++
 rtl/ctrl_opcode_decode.sv | 30 +++
 rtl/multicycle_ctrl_fsm.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and mux-select encodings for the multicycle RV32I control sequencer.
//   opcode_e       : RV32I major opcodes the sequencer understands
//   instr_class_e  : decoded instruction class driving the FSM branch out of DECODE
//   state_t        : sequencer states
//   SRCA_/SRCB_/RES_/IMM_/ALUOP_ : datapath mux and ALU-decoder select encodings
package riscv_ctrl_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned IMM_W = 3;

    typedef enum logic [OPC_W-1:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [3:0] {
        CLS_ILLEGAL,
        CLS_LOAD,
        CLS_STORE,
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC
    } instr_class_e;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_EXECU,
        S_ALUWB,
        S_BRANCH,
        S_JALR,
        S_JAL
    } state_t;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;
    localparam logic [SEL_W-1:0] SRCA_ZERO  = 2'b11;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEMDATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [IMM_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_W-1:0] IMM_J = 3'b011;
    localparam logic [IMM_W-1:0] IMM_U = 3'b100;

    localparam logic [SEL_W-1:0] ALUOP_ADD    = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT  = 2'b10;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode decode: classifies instr[6:0] and selects the immediate format.
//   opcode_i      in  7  instruction opcode field
//   instr_class_o out    instruction class (CLS_ILLEGAL for unknown opcodes)
//   imm_src_o     out 3  immediate format select (I for classes without an immediate)
module ctrl_opcode_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output instr_class_e     instr_class_o,
    output logic [IMM_W-1:0] imm_src_o
);

    always_comb begin
        instr_class_o = CLS_ILLEGAL;
        imm_src_o     = IMM_I;
        case (opcode_i)
            OPC_LOAD:   instr_class_o = CLS_LOAD;
            OPC_STORE:  begin instr_class_o = CLS_STORE;  imm_src_o = IMM_S; end
            OPC_OP:     instr_class_o = CLS_ALU_R;
            OPC_OP_IMM: instr_class_o = CLS_ALU_I;
            OPC_BRANCH: begin instr_class_o = CLS_BRANCH; imm_src_o = IMM_B; end
            OPC_JAL:    begin instr_class_o = CLS_JAL;    imm_src_o = IMM_J; end
            OPC_JALR:   instr_class_o = CLS_JALR;
            OPC_LUI:    begin instr_class_o = CLS_LUI;    imm_src_o = IMM_U; end
            OPC_AUIPC:  begin instr_class_o = CLS_AUIPC;  imm_src_o = IMM_U; end
            default:    ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control sequencer. Steps each instruction through FETCH/DECODE/EXECUTE/
// MEM/WB over a shared ALU/memory datapath and drives its mux selects and write enables.
// Memory uses a req/ready handshake guarded by a timeout watchdog.
//   clk_i, rst_ni        clock, async active-low reset
//   opcode_i             instr[6:0] from the IR (sampled in DECODE/MEMADR/EXECU only)
//   branch_taken_i       branch-condition result from the datapath
//   mem_ready_i          memory completes the current access this cycle
//   mem_req_o/mem_write_o/adr_src_o   memory request, store, address select
//   ir_write_o/pc_write_o/reg_write_o write enables
//   result_src_o/alu_src_a_o/alu_src_b_o/alu_op_o/imm_src_o  datapath selects
//   illegal_o            pulse: unknown opcode in DECODE
//   mem_err_o            sticky: watchdog expired
//   retire_o             pulse: last state of a completed instruction
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [OPC_W-1:0] opcode_i,
    input  logic             branch_taken_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic             adr_src_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             reg_write_o,
    output logic [SEL_W-1:0] result_src_o,
    output logic [SEL_W-1:0] alu_src_a_o,
    output logic [SEL_W-1:0] alu_src_b_o,
    output logic [SEL_W-1:0] alu_op_o,
    output logic [IMM_W-1:0] imm_src_o,
    output logic             illegal_o,
    output logic             mem_err_o,
    output logic             retire_o
);

    localparam bit          WD_EN   = (MEM_TIMEOUT > 0);
    localparam int unsigned WD_W    = WD_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MEM_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_EN ? MEM_TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    instr_class_e      instr_class;
    logic [WD_W-1:0]   wd_cnt_q;
    logic              abort_q;
    logic              mem_err_q;

    logic              mem_req_c;
    logic              mem_ack_c;
    logic              wd_wait_c;
    logic              wd_expire_c;
    logic              write_c, adr_c, ir_c, pc_c, reg_c, illegal_c, retire_c;
    logic [SEL_W-1:0]  res_c, src_a_c, src_b_c, alu_op_c;

    ctrl_opcode_decode u_decode (
        .opcode_i      (opcode_i),
        .instr_class_o (instr_class),
        .imm_src_o     (imm_src_o)
    );

    // Request is Moore on the memory states; suppressed for the single cycle after a timeout.
    assign mem_req_c   = ((state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE))
                         && !abort_q;
    assign mem_ack_c   = mem_req_c && mem_ready_i;
    assign wd_wait_c   = mem_req_c && !mem_ready_i;
    // Fires on the MEM_TIMEOUT-th consecutive waiting cycle.
    assign wd_expire_c = WD_EN && wd_wait_c && (wd_cnt_q == WD_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Watchdog: saturating wait counter, one-cycle request abort, sticky error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q  <= '0;
            abort_q   <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            abort_q   <= wd_expire_c;
            mem_err_q <= mem_err_q || wd_expire_c;
            if (!wd_wait_c || wd_expire_c) begin
                wd_cnt_q <= '0;
            end else if (wd_cnt_q != WD_MAX) begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
        end
    end

    // Next state and Moore/qualified control outputs.
    always_comb begin
        state_d   = state_q;
        write_c   = 1'b0;
        adr_c     = 1'b0;
        ir_c      = 1'b0;
        pc_c      = 1'b0;
        reg_c     = 1'b0;
        illegal_c = 1'b0;
        retire_c  = 1'b0;
        res_c     = RES_ALUOUT;
        src_a_c   = SRCA_PC;
        src_b_c   = SRCB_RS2;
        alu_op_c  = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                src_a_c = SRCA_PC;
                src_b_c = SRCB_FOUR;
                res_c   = RES_ALURESULT;
                ir_c    = mem_ack_c;
                pc_c    = mem_ack_c;
                if (mem_ack_c) state_d = S_DECODE;
            end
            S_DECODE: begin
                src_a_c = SRCA_OLDPC;
                src_b_c = SRCB_IMM;
                case (instr_class)
                    CLS_LOAD, CLS_STORE: state_d = S_MEMADR;
                    CLS_ALU_R:           state_d = S_EXECR;
                    CLS_ALU_I:           state_d = S_EXECI;
                    CLS_BRANCH:          state_d = S_BRANCH;
                    CLS_JAL:             state_d = S_JAL;
                    CLS_JALR:            state_d = S_JALR;
                    CLS_LUI, CLS_AUIPC:  state_d = S_EXECU;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a_c = SRCA_RS1;
                src_b_c = SRCB_IMM;
                state_d = (instr_class == CLS_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_c = 1'b1;
                if (mem_ack_c) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                res_c    = RES_MEMDATA;
                reg_c    = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWRITE: begin
                write_c = 1'b1;
                adr_c   = 1'b1;
                if (mem_ack_c) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXECR: begin
                src_a_c  = SRCA_RS1;
                src_b_c  = SRCB_RS2;
                alu_op_c = ALUOP_FUNCT;
                state_d  = S_ALUWB;
            end
            S_EXECI: begin
                src_a_c  = SRCA_RS1;
                src_b_c  = SRCB_IMM;
                alu_op_c = ALUOP_FUNCT;
                state_d  = S_ALUWB;
            end
            S_EXECU: begin
                src_a_c = (instr_class == CLS_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                src_b_c = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_c    = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                src_a_c  = SRCA_RS1;
                src_b_c  = SRCB_RS2;
                alu_op_c = ALUOP_BRANCH;
                pc_c     = branch_taken_i;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_JALR: begin
                src_a_c = SRCA_RS1;
                src_b_c = SRCB_IMM;
                state_d = S_JAL;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while the ALU forms the link value.
                src_a_c = SRCA_OLDPC;
                src_b_c = SRCB_FOUR;
                pc_c    = 1'b1;
                state_d = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase

        if (wd_expire_c) state_d = S_FETCH;
    end

    // Memory strobes and write enables are masked while reset is held so an access dies at once.
    assign mem_req_o    = mem_req_c && rst_ni;
    assign mem_write_o  = write_c && mem_req_c && rst_ni;
    assign ir_write_o   = ir_c && rst_ni;
    assign pc_write_o   = pc_c && rst_ni;
    assign adr_src_o    = adr_c;
    assign reg_write_o  = reg_c;
    assign result_src_o = res_c;
    assign alu_src_a_o  = src_a_c;
    assign alu_src_b_o  = src_b_c;
    assign alu_op_o     = alu_op_c;
    assign illegal_o    = illegal_c;
    assign retire_o     = retire_c;
    assign mem_err_o    = mem_err_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle expected control words, hand-computed.
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] OP_ADD   = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [6:0] opcode_i = OP_ADD;
    logic       branch_taken_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0] result_src_o, alu_src_a_o, alu_src_b_o, alu_op_o;
    logic [2:0] imm_src_o;
    logic       illegal_o, mem_err_o, retire_o;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ret = 0;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .opcode_i       (opcode_i),
        .branch_taken_i (branch_taken_i),
        .mem_ready_i    (mem_ready_i),
        .mem_req_o      (mem_req_o),
        .mem_write_o    (mem_write_o),
        .adr_src_o      (adr_src_o),
        .ir_write_o     (ir_write_o),
        .pc_write_o     (pc_write_o),
        .reg_write_o    (reg_write_o),
        .result_src_o   (result_src_o),
        .alu_src_a_o    (alu_src_a_o),
        .alu_src_b_o    (alu_src_b_o),
        .alu_op_o       (alu_op_o),
        .imm_src_o      (imm_src_o),
        .illegal_o      (illegal_o),
        .mem_err_o      (mem_err_o),
        .retire_o       (retire_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (retire_o === 1'b1) n_ret++;

    wire [18:0] obs = {mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
                       result_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, illegal_o, retire_o,
                       imm_src_o};

    // Expected control word: req wr adr ir pc rw res a b op ill ret imm
    function automatic logic [18:0] ew(input int unsigned req, wr, adr, ir, pc, rw,
                                       input int unsigned res, a, b, op, ill, ret, imm);
        return {1'(req), 1'(wr), 1'(adr), 1'(ir), 1'(pc), 1'(rw),
                2'(res), 2'(a), 2'(b), 2'(op), 1'(ill), 1'(ret), 3'(imm)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, compare mid-cycle, advance.
    task automatic cyc(input string tag, input logic rdy, input logic br, input logic [18:0] exp);
        mem_ready_i    = rdy;
        branch_taken_i = br;
        #2;
        check(tag, 32'(obs), 32'(exp));
        @(posedge clk_i);
        #1;
    endtask

    // Fetch / decode words for an instruction with immediate format imm
    function automatic logic [18:0] w_fetch(input int unsigned rdy, imm);
        return ew(1, 0, 0, rdy, rdy, 0, 2, 0, 2, 0, 0, 0, imm);
    endfunction
    function automatic logic [18:0] w_dec(input int unsigned imm);
        return ew(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, imm);
    endfunction
    function automatic logic [18:0] w_aluwb(input int unsigned imm);
        return ew(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, imm);
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset: FETCH selects, request and enables masked, no error
        #2;
        check("rst_word", 32'(obs), 32'(ew(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0)));
        check("rst_err", 32'(mem_err_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // add: F D EXECR ALUWB
        opcode_i = OP_ADD;
        cyc("add_f",   1, 0, w_fetch(1, 0));
        cyc("add_d",   1, 0, w_dec(0));
        cyc("add_ex",  1, 0, ew(0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        cyc("add_wb",  1, 0, w_aluwb(0));

        // lw with 3 wait cycles in MEMREAD
        opcode_i = OP_LW;
        cyc("lw_f",    1, 0, w_fetch(1, 0));
        cyc("lw_d",    1, 0, w_dec(0));
        cyc("lw_adr",  1, 0, ew(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            cyc("lw_rd_wait", 0, 0, ew(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("lw_rd",   1, 0, ew(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("lw_wb",   1, 0, ew(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));

        // sw with 2 wait cycles; retire only on the ready cycle
        opcode_i = OP_SW;
        cyc("sw_f",    1, 0, w_fetch(1, 1));
        cyc("sw_d",    1, 0, w_dec(1));
        cyc("sw_adr",  1, 0, ew(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1));
        for (int i = 0; i < 2; i++)
            cyc("sw_wr_wait", 0, 0, ew(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc("sw_wr",   1, 0, ew(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

        // beq taken then not taken
        opcode_i = OP_BEQ;
        cyc("beq1_f",  1, 0, w_fetch(1, 2));
        cyc("beq1_d",  1, 0, w_dec(2));
        cyc("beq1_br", 1, 1, ew(0, 0, 0, 0, 1, 0, 0, 2, 0, 1, 0, 1, 2));
        cyc("beq0_f",  1, 1, w_fetch(1, 2));
        cyc("beq0_d",  1, 1, w_dec(2));
        cyc("beq0_br", 1, 0, ew(0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 1, 2));

        // jalr: JALR JAL ALUWB; opcode change after DECODE must not matter
        opcode_i = OP_JALR;
        cyc("jalr_f",  1, 0, w_fetch(1, 0));
        cyc("jalr_d",  1, 0, w_dec(0));
        cyc("jalr_x",  1, 0, ew(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        opcode_i = OP_BAD;
        cyc("jalr_j",  1, 0, ew(0, 0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0, 0));
        cyc("jalr_wb", 1, 0, w_aluwb(0));

        // illegal opcode: pulse in DECODE, back to FETCH
        cyc("bad_f",   1, 0, w_fetch(1, 0));
        cyc("bad_d",   1, 0, ew(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        cyc("bad_ret", 0, 0, w_fetch(0, 0));

        // lui / auipc / addi / jal
        opcode_i = OP_LUI;
        cyc("lui_f",   1, 0, w_fetch(1, 4));
        cyc("lui_d",   1, 0, w_dec(4));
        cyc("lui_ex",  1, 0, ew(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 4));
        cyc("lui_wb",  1, 0, w_aluwb(4));
        opcode_i = OP_AUIPC;
        cyc("auipc_f", 1, 0, w_fetch(1, 4));
        cyc("auipc_d", 1, 0, w_dec(4));
        cyc("auipc_ex",1, 0, ew(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4));
        cyc("auipc_wb",1, 0, w_aluwb(4));
        opcode_i = OP_ADDI;
        cyc("addi_f",  1, 0, w_fetch(1, 0));
        cyc("addi_d",  1, 0, w_dec(0));
        cyc("addi_ex", 1, 0, ew(0, 0, 0, 0, 0, 0, 0, 2, 1, 2, 0, 0, 0));
        cyc("addi_wb", 1, 0, w_aluwb(0));
        opcode_i = OP_JAL;
        cyc("jal_f",   1, 0, w_fetch(1, 3));
        cyc("jal_d",   1, 0, w_dec(3));
        cyc("jal_j",   1, 0, ew(0, 0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0, 3));
        cyc("jal_wb",  1, 0, w_aluwb(3));

        check("retire_count", 32'(n_ret), 32'd10);
        check("err_clean", 32'(mem_err_o), 32'd0);

        // Watchdog: ready stuck low in FETCH for 4 cycles
        opcode_i = OP_ADD;
        for (int i = 0; i < 4; i++) begin
            cyc("wd_wait", 0, 0, w_fetch(0, 0));
        end
        opcode_i = OP_SW;
        #2;
        check("wd_err_set", 32'(mem_err_o), 32'd1);
        // Abort cycle: request dropped even though ready is now high
        cyc("wd_abort", 1, 0, ew(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 1));
        cyc("wd_resume", 1, 0, w_fetch(1, 1));
        check("wd_err_sticky", 32'(mem_err_o), 32'd1);
        cyc("wd_sw_d",   1, 0, w_dec(1));
        cyc("wd_sw_adr", 1, 0, ew(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1));
        cyc("wd_sw_wr",  0, 0, ew(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // Reset asserted mid-MEMWRITE: store dropped immediately, error cleared
        mem_ready_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("midrst_word", 32'(obs), 32'(ew(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 1)));
        check("midrst_err", 32'(mem_err_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        opcode_i = OP_ADD;
        cyc("post_rst_f", 1, 0, w_fetch(1, 0));
        cyc("post_rst_d", 1, 0, w_dec(0));
        check("final_retire_count", 32'(n_ret), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
